// File: rtl/multisim_arb_pkg.sv
// Shared types for the push arbiter: buffer state enum and source-index width helper.
package multisim_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Source index width; never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multisim_push_arbiter_if.sv
// Requester-side and server-side handshake bundle of the push arbiter.
interface multisim_push_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
);
    import multisim_arb_pkg::*;
    localparam int IDW = idw(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_vld;
    logic [NUM_REQ-1:0]                 req_rdy;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic                               out_vld;
    logic                               out_rdy;
    logic [DATA_WIDTH-1:0]              out_data;
    logic [IDW-1:0]                     out_src;

    modport slave (
        input  req_vld, req_data, out_rdy,
        output req_rdy, out_vld, out_data, out_src
    );

    modport master (
        output req_vld, req_data, out_rdy,
        input  req_rdy, out_vld, out_data, out_src
    );

endinterface

// File: rtl/multisim_rr_arbiter.sv
// Combinational round-robin grant: first valid request at or above ptr, wrapping.
module multisim_rr_arbiter
    import multisim_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        // ptr is always < NUM_REQ, so one conditional subtract is a full modulo.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/multisim_push_arbiter.sv
// Round-robin N:1 push arbiter with a one-word output buffer.
// Optional per-requester accept counters enabled by MULTISIM_PUSH_ARB_STATS_EN.
module multisim_push_arbiter
    import multisim_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multisim_push_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0][31:0] stat_cnt
);

    localparam int IDW = idw(NUM_REQ);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]        src_q, src_d;
    logic [IDW-1:0]        ptr_q, ptr_d;

    logic [NUM_REQ-1:0]    gnt;
    logic [IDW-1:0]        gnt_idx;
    logic                  gnt_vld;
    logic                  load_ok;
    logic                  accept;

    multisim_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (bus.req_vld),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // rst_n gates readiness so nothing looks accepted while reset is held.
    assign load_ok     = ((state_q == EMPTY) || bus.out_rdy) && rst_n;
    assign bus.req_rdy = gnt & {NUM_REQ{load_ok}};
    assign accept      = gnt_vld && load_ok;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = FULL;
            data_d  = bus.req_data[gnt_idx];
            src_d   = gnt_idx;
            ptr_d   = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == FULL && bus.out_rdy) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_vld  = (state_q == FULL);
    assign bus.out_data = data_q;
    assign bus.out_src  = src_q;

`ifdef MULTISIM_PUSH_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d[gnt_idx] = cnt_q[gnt_idx] + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stat_cnt = cnt_q;
`else
    assign stat_cnt = '0;
`endif

endmodule
